pulse_gen_array: RTL and testbench

//  N_CH-channel level-to-pulse converter for the logical-layer control path.

---
 rtl/pulse_pkg.sv | 24 ++
 rtl/pulse_gen_ch.sv | 97 +++++++++
 rtl/pulse_gen_array.sv | 55 +++++
 tb/tb_pulse_gen_array.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared edge-mode encoding and parameter limits for the pulse generator array.
package pulse_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_OFF  = 2'b11
    } edge_mode_t;

    localparam int unsigned MAX_N_CH        = 32;
    localparam int unsigned MAX_PULSE_W     = 255;
    localparam int unsigned MAX_SYNC_STAGES = 3;

    function automatic logic edge_hit(input edge_mode_t mode, input logic rise, input logic fall);
        case (mode)
            EDGE_RISE: return rise;
            EDGE_FALL: return fall;
            EDGE_BOTH: return rise | fall;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pulse_gen_ch.sv
// One level-to-pulse channel: optional synchroniser, edge select, pulse counter,
// retrigger policy and sticky overrun flag.
module pulse_gen_ch
    import pulse_pkg::*;
#(
    parameter int unsigned PULSE_W     = 1,
    parameter int unsigned SYNC_STAGES = 0,
    parameter int unsigned RETRIG      = 0,
    parameter int unsigned CNT_W       = $clog2(PULSE_W + 1)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       lvl_sig,
    input  logic [1:0] edge_mode,
    input  logic       ovr_clr,
    output logic       pulse_sig,
    output logic       busy,
    output logic       overrun
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s;
    logic             hist_q;
    logic             primed_q;
    logic             pulse_q;
    logic             ovr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             hit;
    logic             edge_det;
    logic             ovr_set;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = lvl_sig;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= lvl_sig;
                    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // A non-retriggerable edge arriving while the counter runs (even on its
    // last cycle) is dropped but still lets the counter continue to drain.
    always_comb begin
        hit      = edge_hit(edge_mode_t'(edge_mode), s & ~hist_q, ~s & hist_q);
        edge_det = primed_q & hit;
        ovr_set  = 1'b0;
        cnt_d    = cnt_q;
        if (edge_det && (cnt_q == '0 || RETRIG != 0)) begin
            cnt_d = CNT_LOAD;
        end else begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_ONE;
            end
            ovr_set = edge_det;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hist_q   <= 1'b0;
            primed_q <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            hist_q   <= s;
            primed_q <= 1'b1;
            cnt_q    <= cnt_d;
            pulse_q  <= (cnt_d != '0);
            if (ovr_set) begin
                ovr_q <= 1'b1;
            end else if (ovr_clr) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign pulse_sig = pulse_q;
    assign busy      = pulse_q;
    assign overrun   = ovr_q;

endmodule

// File: rtl/pulse_gen_array.sv
// N_CH independent level-to-pulse channels; this level only slices the buses.
module pulse_gen_array
    import pulse_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned PULSE_W     = 1,
    parameter int unsigned SYNC_STAGES = 0,
    parameter int unsigned RETRIG      = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_CH-1:0]   lvl_sig,
    input  logic [2*N_CH-1:0] edge_mode,
    input  logic [N_CH-1:0]   ovr_clr,
    output logic [N_CH-1:0]   pulse_sig,
    output logic [N_CH-1:0]   busy,
    output logic [N_CH-1:0]   overrun
);

    localparam int unsigned CNT_W = $clog2(PULSE_W + 1);

    generate
        if (N_CH < 1 || N_CH > MAX_N_CH) begin : g_bad_n_ch
            $error("pulse_gen_array: N_CH out of range 1..32");
        end
        if (PULSE_W < 1 || PULSE_W > MAX_PULSE_W) begin : g_bad_pulse_w
            $error("pulse_gen_array: PULSE_W out of range 1..255");
        end
        if (SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
            $error("pulse_gen_array: SYNC_STAGES out of range 0..3");
        end
        if (RETRIG > 1) begin : g_bad_retrig
            $error("pulse_gen_array: RETRIG must be 0 or 1");
        end

        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            pulse_gen_ch #(
                .PULSE_W     (PULSE_W),
                .SYNC_STAGES (SYNC_STAGES),
                .RETRIG      (RETRIG),
                .CNT_W       (CNT_W)
            ) u_ch (
                .clk       (clk),
                .reset_n   (reset_n),
                .lvl_sig   (lvl_sig[i]),
                .edge_mode (edge_mode[2*i +: 2]),
                .ovr_clr   (ovr_clr[i]),
                .pulse_sig (pulse_sig[i]),
                .busy      (busy[i]),
                .overrun   (overrun[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pulse_gen_array.sv
// Six differently-parameterised arrays share one stimulus; a timestamp model
// predicts every output each cycle, and directed literals pin the scenarios.
module tb_pulse_gen_array;
    import pulse_pkg::*;

    localparam int NI   = 6;
    localparam int NONE = -1000000;

    // Instances: 0 A(W1,S0,R0) 1 B(W4,S2,R0) 2 C(W4,S0,R1) 3 D(W4,S0,R0) 4 E(W8,S0,R0) 5 F(W1,S0,R1)
    function automatic int unsigned pw_of(input int g);
        case (g)
            1, 2, 3: return 4;
            4:       return 8;
            default: return 1;
        endcase
    endfunction

    function automatic int unsigned ss_of(input int g);
        return (g == 1) ? 2 : 0;
    endfunction

    function automatic int unsigned rt_of(input int g);
        return (g == 2 || g == 5) ? 1 : 0;
    endfunction

    logic       clk;
    logic       reset_n;
    logic [3:0] lvl_sig;
    logic [7:0] edge_mode;
    logic [3:0] ovr_clr;
    logic [3:0] pul [NI];
    logic [3:0] bsy [NI];
    logic [3:0] ovr [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        pulse_gen_array #(
            .N_CH        (4),
            .PULSE_W     (pw_of(g)),
            .SYNC_STAGES (ss_of(g)),
            .RETRIG      (rt_of(g))
        ) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .lvl_sig   (lvl_sig),
            .edge_mode (edge_mode),
            .ovr_clr   (ovr_clr),
            .pulse_sig (pul[g]),
            .busy      (bsy[g]),
            .overrun   (ovr[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // Inputs as seen at each posedge, consumed by the model on the next negedge.
    logic       cap_valid = 1'b0;
    logic       cap_rst;
    logic [3:0] cap_lvl;
    logic [7:0] cap_mode;
    logic [3:0] cap_clr;

    always @(posedge clk) begin
        cap_valid <= 1'b1;
        cap_rst   <= reset_n;
        cap_lvl   <= lvl_sig;
        cap_mode  <= edge_mode;
        cap_clr   <= ovr_clr;
    end

    bit         rst_h [2048];
    logic [3:0] lvl_h [2048];
    int         last_acc [NI][4];
    bit         movr [NI][4];
    int         cyc = 0;
    bit         seen_reset = 1'b0;

    // Level seen by edge detection at posedge n: the input from SYNC posedges
    // earlier, or 0 if any reset posedge lies in between.
    function automatic logic s_val(input int sync, input int n, input int ch);
        if (n - sync < 0) return 1'b0;
        for (int j = 1; j <= sync; j++) begin
            if (!rst_h[n-j]) return 1'b0;
        end
        return lvl_h[n-sync][ch];
    endfunction

    logic [3:0] ep, eo;
    int         w_m, s_m;
    bit         r_m, primed, sv, hv, hit, set;
    logic [1:0] m;

    always @(negedge clk) begin
        if (cap_valid) begin
            rst_h[cyc] = cap_rst;
            lvl_h[cyc] = cap_lvl;
            if (!cap_rst) seen_reset = 1'b1;
            if (seen_reset) begin
                for (int g = 0; g < NI; g++) begin
                    w_m = int'(pw_of(g));
                    s_m = int'(ss_of(g));
                    r_m = (rt_of(g) != 0);
                    for (int ch = 0; ch < 4; ch++) begin
                        if (!cap_rst) begin
                            last_acc[g][ch] = NONE;
                            movr[g][ch]     = 1'b0;
                        end else begin
                            primed = (cyc >= 1) && rst_h[cyc-1];
                            sv     = s_val(s_m, cyc, ch);
                            hv     = primed ? s_val(s_m, cyc - 1, ch) : 1'b0;
                            m      = cap_mode[2*ch +: 2];
                            case (m)
                                2'b00:   hit = sv && !hv;
                                2'b01:   hit = !sv && hv;
                                2'b10:   hit = (sv != hv);
                                default: hit = 1'b0;
                            endcase
                            set = 1'b0;
                            if (primed && hit) begin
                                if (r_m || (cyc - last_acc[g][ch] > w_m)) last_acc[g][ch] = cyc;
                                else set = 1'b1;
                            end
                            if (set) movr[g][ch] = 1'b1;
                            else if (cap_clr[ch]) movr[g][ch] = 1'b0;
                        end
                        ep[ch] = (cyc - last_acc[g][ch] < w_m);
                        eo[ch] = movr[g][ch];
                    end
                    chk($sformatf("pulse_i%0d", g), pul[g], ep);
                    chk($sformatf("busy_i%0d", g), bsy[g], ep);
                    chk($sformatf("overrun_i%0d", g), ovr[g], eo);
                end
            end
            cyc++;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    logic [7:0] exp_b, exp_c, exp_d, exp_o;

    initial begin
        reset_n   = 1'b0;
        lvl_sig   = '0;
        edge_mode = '0;
        ovr_clr   = '0;
        repeat (3) step();
        reset_n = 1'b1;
        repeat (2) step();

        // Defaults: single-cycle pulse on a rise, nothing on the later fall.
        lvl_sig[0] = 1'b1;
        step();
        chk("t1_a_on", {3'b0, pul[0][0]}, 4'b0001);
        chk("t1_c_on", {3'b0, pul[2][0]}, 4'b0001);
        step();
        chk("t1_a_off", {3'b0, pul[0][0]}, 4'b0000);
        repeat (9) step();
        lvl_sig[0] = 1'b0;
        repeat (3) step();
        chk("t1_fall_quiet", {3'b0, pul[0][0]}, 4'b0000);

        // Falling edge through a two-stage synchroniser, 4-cycle pulse.
        edge_mode[3:2] = EDGE_FALL;
        step();
        lvl_sig[1] = 1'b1;
        repeat (6) step();
        lvl_sig[1] = 1'b0;
        exp_b = 8'b0011_1100;
        for (int j = 0; j < 8; j++) begin
            step();
            chk($sformatf("t2_b_pulse_%0d", j), {3'b0, pul[1][1]}, {3'b0, exp_b[j]});
            chk($sformatf("t2_b_busy_%0d", j), {3'b0, bsy[1][1]}, {3'b0, exp_b[j]});
        end

        // Second rise two cycles after the first: dropped (D) or stretched (C).
        repeat (2) step();
        exp_c = 8'b0011_1111;
        exp_d = 8'b0000_1111;
        exp_o = 8'b1111_1100;
        for (int j = 0; j < 8; j++) begin
            lvl_sig[2] = (j != 1);
            step();
            chk($sformatf("t3_d_pulse_%0d", j), {3'b0, pul[3][2]}, {3'b0, exp_d[j]});
            chk($sformatf("t4_c_pulse_%0d", j), {3'b0, pul[2][2]}, {3'b0, exp_c[j]});
            chk($sformatf("t3_d_ovr_%0d", j), {3'b0, ovr[3][2]}, {3'b0, exp_o[j]});
            chk($sformatf("t4_c_ovr_%0d", j), {3'b0, ovr[2][2]}, 4'b0000);
        end
        ovr_clr[2] = 1'b1;
        step();
        ovr_clr[2] = 1'b0;
        chk("t3_d_ovr_clr", {3'b0, ovr[3][2]}, 4'b0000);

        // PULSE_W=1 with an edge every cycle.
        edge_mode[3:2] = EDGE_BOTH;
        step();
        for (int j = 0; j < 6; j++) begin
            lvl_sig[1] = ~lvl_sig[1];
            step();
            chk($sformatf("w1_a_alt_%0d", j), {3'b0, pul[0][1]}, (j % 2 == 0) ? 4'b0001 : 4'b0000);
            chk($sformatf("w1_f_hold_%0d", j), {3'b0, pul[5][1]}, 4'b0001);
        end
        chk("w1_a_ovr", {3'b0, ovr[0][1]}, 4'b0001);
        chk("w1_f_ovr", {3'b0, ovr[5][1]}, 4'b0000);

        // Level high through reset release, channel enabled later: no pulse.
        edge_mode[7:6] = EDGE_OFF;
        lvl_sig = 4'b1000;
        step();
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        repeat (4) step();
        edge_mode[7:6] = EDGE_RISE;
        for (int j = 0; j < 4; j++) begin
            step();
            chk($sformatf("t5_a_quiet_%0d", j), {3'b0, pul[0][3]}, 4'b0000);
            chk($sformatf("t5_b_quiet_%0d", j), {3'b0, pul[1][3]}, 4'b0000);
        end
        lvl_sig[3] = 1'b0;
        step();
        lvl_sig[3] = 1'b1;
        step();
        chk("t5_a_genuine", {3'b0, pul[0][3]}, 4'b0001);

        // Reset on the third cycle of an 8-cycle pulse.
        lvl_sig[0] = 1'b1;
        step();
        chk("t6_e_on", {3'b0, pul[4][0]}, 4'b0001);
        repeat (2) step();
        chk("t6_e_still_on", {3'b0, pul[4][0]}, 4'b0001);
        reset_n = 1'b0;
        step();
        chk("t6_e_pulse_rst", pul[4], 4'b0000);
        chk("t6_e_busy_rst", bsy[4], 4'b0000);
        chk("t6_e_ovr_rst", ovr[4], 4'b0000);
        reset_n = 1'b1;
        repeat (2) step();

        // Overrun event and clear in the same cycle: set wins.
        lvl_sig[2] = 1'b1;
        step();
        lvl_sig[2] = 1'b0;
        step();
        lvl_sig[2] = 1'b1;
        ovr_clr[2] = 1'b1;
        step();
        ovr_clr[2] = 1'b0;
        chk("t6_d_set_wins", {3'b0, ovr[3][2]}, 4'b0001);
        repeat (10) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
